// File: rtl/mdu_seq_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : mdu_seq_pkg                                              |
// | Brief  : RV32M funct3 codes, multiplier types, FSM state encoding |
// | Rev    : 1.0  initial release                                     |
// +------------------------------------------------------------------+
package mdu_seq_pkg;

    localparam logic [2:0] c_f3_mul    = 3'b000;
    localparam logic [2:0] c_f3_mulh   = 3'b001;
    localparam logic [2:0] c_f3_mulhsu = 3'b010;
    localparam logic [2:0] c_f3_mulhu  = 3'b011;
    localparam logic [2:0] c_f3_div    = 3'b100;
    localparam logic [2:0] c_f3_divu   = 3'b101;
    localparam logic [2:0] c_f3_rem    = 3'b110;
    localparam logic [2:0] c_f3_remu   = 3'b111;

    localparam logic [1:0] c_mult_type_low32      = 2'b00;
    localparam logic [1:0] c_mult_type_sxs_high32 = 2'b01;
    localparam logic [1:0] c_mult_type_sxu_high32 = 2'b10;
    localparam logic [1:0] c_mult_type_uxu_high32 = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MUL_WAIT = 2'd1,
        S_DIV_RUN  = 2'd2,
        S_DONE     = 2'd3
    } mdu_state_t;

    function automatic logic [1:0] mult_type_of(input logic [2:0] f3);
        case (f3)
            c_f3_mulh:   return c_mult_type_sxs_high32;
            c_f3_mulhsu: return c_mult_type_sxu_high32;
            c_f3_mulhu:  return c_mult_type_uxu_high32;
            default:     return c_mult_type_low32;
        endcase
    endfunction

    function automatic logic is_div_op(input logic [2:0] f3);
        return (f3 == c_f3_div) || (f3 == c_f3_divu) || (f3 == c_f3_rem) || (f3 == c_f3_remu);
    endfunction

    function automatic logic is_signed_div(input logic [2:0] f3);
        return (f3 == c_f3_div) || (f3 == c_f3_rem);
    endfunction

    function automatic logic is_rem_op(input logic [2:0] f3);
        return (f3 == c_f3_rem) || (f3 == c_f3_remu);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_seq_div_iter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : mdu_seq_div_iter                                         |
// | Brief  : one-bit-per-cycle restoring divider on magnitudes        |
// | Rev    : 1.0  initial release                                     |
// +------------------------------------------------------------------+
module mdu_seq_div_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quot_nxt,
    output logic [31:0] rem_nxt
);

    logic [31:0] r_quot;
    logic [31:0] r_rem;
    logic [31:0] r_divisor;
    logic [32:0] w_rem_shift;
    logic        w_ge;

    // The outputs are the values after the current step, so the caller can
    // register the final result on the same edge as the last iteration.
    always_comb begin
        w_rem_shift = {r_rem, r_quot[31]};
        w_ge        = (w_rem_shift >= {1'b0, r_divisor});
        rem_nxt     = w_ge ? (w_rem_shift[31:0] - r_divisor) : w_rem_shift[31:0];
        quot_nxt    = {r_quot[30:0], w_ge};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_quot    <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
        end else if (load) begin
            r_quot    <= dividend;
            r_rem     <= '0;
            r_divisor <= divisor;
        end else if (step) begin
            r_quot    <= quot_nxt;
            r_rem     <= rem_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mdu_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : mdu_seq                                                  |
// | Brief  : sequential RV32M unit; divider built with MDU_SEQ_DIV_EN |
// | Rev    : 1.0  initial release                                     |
// +------------------------------------------------------------------+
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int MULT_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        flush_i,
    output logic        mult_valid_o,
    output logic [1:0]  mult_type_o,
    output logic [31:0] mult_a_o,
    output logic [31:0] mult_b_o,
    input  logic [31:0] mult_result_i,
    output logic        stall_o,
    output logic        rd_we_o,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] rd_data_o
);

    localparam logic [4:0] c_mul_last = 5'(MULT_LAT - 1);

    mdu_state_t  r_state;
    logic [4:0]  r_cnt;
    logic [2:0]  r_funct3;
    logic [31:0] r_rs1;
    logic [31:0] r_rs2;
    logic [4:0]  r_rd_addr;

    assign mult_type_o = mult_type_of(r_funct3);
    assign mult_a_o    = r_rs1;
    assign mult_b_o    = r_rs2;
    assign stall_o     = ((r_state == S_IDLE) && start_i) ||
                         (r_state == S_MUL_WAIT) || (r_state == S_DIV_RUN);

`ifdef MDU_SEQ_DIV_EN
    localparam logic [4:0] c_div_last = 5'd31;

    logic        r_neg_q;
    logic        r_neg_r;
    logic        w_signed;
    logic        w_ovf;
    logic        w_load;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_q_nxt;
    logic [31:0] w_r_nxt;
    logic [31:0] w_zero_res;
    logic [31:0] w_ovf_res;
    logic [31:0] w_div_res;

    always_comb begin
        w_signed   = is_signed_div(funct3_i);
        w_a_mag    = (w_signed && rs1_i[31]) ? -rs1_i : rs1_i;
        w_b_mag    = (w_signed && rs2_i[31]) ? -rs2_i : rs2_i;
        w_ovf      = w_signed && (rs1_i == 32'h8000_0000) && (rs2_i == 32'hFFFF_FFFF);
        w_zero_res = is_rem_op(funct3_i) ? rs1_i : 32'hFFFF_FFFF;
        w_ovf_res  = is_rem_op(funct3_i) ? 32'h0000_0000 : 32'h8000_0000;
        // Remainder follows the dividend's sign, quotient the sign product.
        w_div_res  = is_rem_op(r_funct3) ? (r_neg_r ? -w_r_nxt : w_r_nxt)
                                         : (r_neg_q ? -w_q_nxt : w_q_nxt);
    end

    assign w_load = (r_state == S_IDLE) && start_i && !flush_i && is_div_op(funct3_i);

    mdu_seq_div_iter u_div_iter (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .step     (r_state == S_DIV_RUN),
        .dividend (w_a_mag),
        .divisor  (w_b_mag),
        .quot_nxt (w_q_nxt),
        .rem_nxt  (w_r_nxt)
    );
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_funct3     <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_rd_addr    <= '0;
            mult_valid_o <= 1'b0;
            rd_we_o      <= 1'b0;
            rd_addr_o    <= '0;
            rd_data_o    <= '0;
`ifdef MDU_SEQ_DIV_EN
            r_neg_q      <= 1'b0;
            r_neg_r      <= 1'b0;
`endif
        end else begin
            mult_valid_o <= 1'b0;
            rd_we_o      <= 1'b0;
            rd_addr_o    <= '0;
            rd_data_o    <= '0;
            if (flush_i) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start_i) begin
                            r_funct3  <= funct3_i;
                            r_rs1     <= rs1_i;
                            r_rs2     <= rs2_i;
                            r_rd_addr <= rd_addr_i;
                            r_cnt     <= '0;
                            if (!is_div_op(funct3_i)) begin
                                r_state      <= S_MUL_WAIT;
                                mult_valid_o <= 1'b1;
                            end
`ifdef MDU_SEQ_DIV_EN
                            else if ((rs2_i == 32'h0) || w_ovf) begin
                                r_state   <= S_DONE;
                                rd_we_o   <= 1'b1;
                                rd_addr_o <= rd_addr_i;
                                rd_data_o <= (rs2_i == 32'h0) ? w_zero_res : w_ovf_res;
                            end else begin
                                r_state <= S_DIV_RUN;
                                r_neg_q <= w_signed && (rs1_i[31] ^ rs2_i[31]);
                                r_neg_r <= w_signed && rs1_i[31];
                            end
`else
                            else begin
                                r_state   <= S_DONE;
                                rd_we_o   <= 1'b1;
                                rd_addr_o <= rd_addr_i;
                            end
`endif
                        end
                    end
                    S_MUL_WAIT: begin
                        if (r_cnt == c_mul_last) begin
                            r_state   <= S_DONE;
                            rd_we_o   <= 1'b1;
                            rd_addr_o <= r_rd_addr;
                            rd_data_o <= mult_result_i;
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
`ifdef MDU_SEQ_DIV_EN
                    S_DIV_RUN: begin
                        if (r_cnt == c_div_last) begin
                            r_state   <= S_DONE;
                            rd_we_o   <= 1'b1;
                            rd_addr_o <= r_rd_addr;
                            rd_data_o <= w_div_res;
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
`endif
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_mdu_seq                                               |
// | Brief  : scoreboard bench for mdu_seq with a latency-LAT multiplier|
// | Rev    : 1.0  initial release                                     |
// +------------------------------------------------------------------+
module tb_mdu_seq;

    localparam int          LAT  = 3;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;
    localparam logic [2:0]  F_MUL = 3'd0, F_MULH = 3'd1, F_MULHSU = 3'd2, F_MULHU = 3'd3;
    localparam logic [2:0]  F_DIV = 3'd4, F_DIVU = 3'd5, F_REM = 3'd6, F_REMU = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, flush_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_i, rs2_i;
    logic [4:0]  rd_addr_i;
    logic        mult_valid_o;
    logic [1:0]  mult_type_o;
    logic [31:0] mult_a_o, mult_b_o, mult_result_i;
    logic        stall_o, rd_we_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;

    int cyc     = 0;
    int n_check = 0;
    int n_fail  = 0;
    int n_ops   = 0;

    typedef struct {
        string       name;
        logic [4:0]  addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mdu_seq #(.MULT_LAT(LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .funct3_i      (funct3_i),
        .rs1_i         (rs1_i),
        .rs2_i         (rs2_i),
        .rd_addr_i     (rd_addr_i),
        .flush_i       (flush_i),
        .mult_valid_o  (mult_valid_o),
        .mult_type_o   (mult_type_o),
        .mult_a_o      (mult_a_o),
        .mult_b_o      (mult_b_o),
        .mult_result_i (mult_result_i),
        .stall_o       (stall_o),
        .rd_we_o       (rd_we_o),
        .rd_addr_o     (rd_addr_o),
        .rd_data_o     (rd_data_o)
    );

    // External multiplier: result is present only in the cycle the DUT should capture it.
    function automatic logic [31:0] mul_model(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        case (t)
            2'b01:   p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            2'b10:   p = {{32{a[31]}}, a} * {32'h0, b};
            default: p = {32'h0, a} * {32'h0, b};
        endcase
        return (t == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    logic [7:0]  pv = 8'h0;
    logic [31:0] pr [8];
    always @(posedge clk) begin
        pv    <= {pv[6:0], mult_valid_o};
        pr[0] <= mul_model(mult_type_o, mult_a_o, mult_b_o);
        for (int k = 1; k < 8; k++) pr[k] <= pr[k-1];
    end

    generate
        if (LAT == 1) begin : g_lat1
            assign mult_result_i = mult_valid_o ? mul_model(mult_type_o, mult_a_o, mult_b_o) : JUNK;
        end else begin : g_latn
            assign mult_result_i = pv[LAT-2] ? pr[LAT-2] : JUNK;
        end
    endgenerate

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_check++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every writeback must match the oldest expectation, including its cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst && rd_we_o) begin
            if (sb.size() == 0) begin
                n_check++;
                n_fail++;
                $display("FAIL unexpected_wb: actual addr %0d data %h required no writeback", rd_addr_o, rd_data_o);
            end else begin
                e = sb.pop_front();
                check({e.name, "_data"}, rd_data_o, e.data);
                check({e.name, "_addr"}, 32'(rd_addr_o), 32'(e.addr));
                check({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
                check({e.name, "_stall_done"}, 32'(stall_o), 32'h0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        for (int n = 0; n < 60 && sb.size() != 0; n++) tick();
        check({name, "_drained"}, 32'(sb.size()), 32'h0);
        tick();
        tick();
    endtask

    // Issues one op in a fresh cycle 0 and expects its writeback lat cycles later.
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res, input int lat,
                          input logic [1:0] typ);
        exp_t e;
        n_ops++;
        tick();
        start_i = 1'b1; funct3_i = f3; rs1_i = a; rs2_i = b;
        rd_addr_i = 5'(n_ops % 31 + 1);
        e.name = name; e.addr = rd_addr_i; e.data = res; e.cyc = cyc + lat;
        sb.push_back(e);
        tick();
        start_i = 1'b0;
        @(negedge clk);
        check({name, "_stall_c1"}, 32'(stall_o), 32'(lat > 1));
        check({name, "_mvalid_c1"}, 32'(mult_valid_o), 32'(f3[2] == 1'b0));
        if (f3[2] == 1'b0) check({name, "_mtype"}, 32'(mult_type_o), 32'(typ));
        wait_drain(name);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        exp_t e;
        rst = 1'b0; start_i = 1'b0; flush_i = 1'b0;
        funct3_i = '0; rs1_i = '0; rs2_i = '0; rd_addr_i = '0;
        #3;
        check("rst_stall", 32'(stall_o), 32'h0);
        check("rst_rd_we", 32'(rd_we_o), 32'h0);
        check("rst_rd_data", rd_data_o, 32'h0);
        check("rst_mvalid", 32'(mult_valid_o), 32'h0);
        check("rst_mult_a", mult_a_o, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // MUL 7 x 6 with start_i held through DONE: no second op may be accepted.
        tick();
        start_i = 1'b1; funct3_i = F_MUL; rs1_i = 32'd7; rs2_i = 32'd6; rd_addr_i = 5'd5;
        e.name = "mul7x6"; e.addr = 5'd5; e.data = 32'd42; e.cyc = cyc + LAT + 1;
        sb.push_back(e);
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            check("mul7x6_stall", 32'(stall_o), 32'(c <= LAT));
            check("mul7x6_mvalid", 32'(mult_valid_o), 32'(c == 1));
            if (c == 1) begin
                check("mul7x6_mtype", 32'(mult_type_o), 32'h0);
                check("mul7x6_mult_a", mult_a_o, 32'd7);
                check("mul7x6_mult_b", mult_b_o, 32'd6);
            end
            tick();
            if (c == 4) start_i = 1'b0;
        end
        wait_drain("mul7x6");

        run_op("mulhu_max", F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT + 1, 2'b11);
        run_op("mulh_neg", F_MULH, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, LAT + 1, 2'b01);
        run_op("mulhsu", F_MULHSU, 32'hFFFF_FFFE, 32'h8000_0000, 32'hFFFF_FFFF, LAT + 1, 2'b10);
        run_op("mulh_pos", F_MULH, 32'hFFFF_FFFE, 32'h8000_0000, 32'h0000_0001, LAT + 1, 2'b01);
        run_op("mul_low", F_MUL, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000, LAT + 1, 2'b00);

`ifdef MDU_SEQ_DIV_EN
        run_op("div_m7_2", F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 2'b00);
        run_op("rem_m7_2", F_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 2'b00);
        run_op("div_7_m2", F_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 2'b00);
        run_op("rem_7_m2", F_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 2'b00);
        run_op("divu_100_7", F_DIVU, 32'd100, 32'd7, 32'd14, 33, 2'b00);
        run_op("remu_max_16", F_REMU, 32'hFFFF_FFFF, 32'd16, 32'd15, 33, 2'b00);
        run_op("div_min_2", F_DIV, 32'h8000_0000, 32'd2, 32'hC000_0000, 33, 2'b00);
        run_op("remu_min_max", F_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 2'b00);
        run_op("divu_5_0", F_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 2'b00);
        run_op("rem_m5_0", F_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1, 2'b00);
        run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 2'b00);
        run_op("rem_ovf", F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 2'b00);

        // Flush a DIV in cycle 10; restart in cycle 12.
        tick();
        start_i = 1'b1; funct3_i = F_DIV; rs1_i = 32'd1000; rs2_i = 32'd3; rd_addr_i = 5'd20;
        tick();
        start_i = 1'b0;
        repeat (9) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        @(negedge clk);
        check("div_flush_idle", 32'(stall_o), 32'h0);
        run_op("div_after_flush", F_DIVU, 32'd100, 32'd7, 32'd14, 33, 2'b00);
`else
        run_op("nodiv_div", F_DIV, 32'd5, 32'd0, 32'h0, 1, 2'b00);
        run_op("nodiv_remu", F_REMU, 32'd100, 32'd7, 32'h0, 1, 2'b00);
`endif

        // Flush a MUL in MUL_WAIT; its late result must be dropped.
        tick();
        start_i = 1'b1; funct3_i = F_MUL; rs1_i = 32'd2; rs2_i = 32'd3; rd_addr_i = 5'd8;
        tick();
        start_i = 1'b0;
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        @(negedge clk);
        check("mul_flush_idle", 32'(stall_o), 32'h0);
        check("mul_flush_no_we", 32'(rd_we_o), 32'h0);
        run_op("mul_after_flush", F_MUL, 32'd2, 32'd3, 32'd6, LAT + 1, 2'b00);

        // Flush beats start in IDLE.
        tick();
        start_i = 1'b1; flush_i = 1'b1; funct3_i = F_MUL; rs1_i = 32'd4; rs2_i = 32'd4;
        tick();
        start_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        check("flush_prio_idle", 32'(stall_o), 32'h0);
        check("flush_prio_mvalid", 32'(mult_valid_o), 32'h0);
        repeat (8) tick();

        // Reset in MUL_WAIT clears outputs immediately; the late result is ignored.
        tick();
        start_i = 1'b1; funct3_i = F_MULHU; rs1_i = 32'd9; rs2_i = 32'd9; rd_addr_i = 5'd12;
        tick();
        start_i = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check("rst_mid_stall", 32'(stall_o), 32'h0);
        check("rst_mid_mult_a", mult_a_o, 32'h0);
        check("rst_mid_mtype", 32'(mult_type_o), 32'h0);
        check("rst_mid_rd_we", 32'(rd_we_o), 32'h0);
        tick();
        rst = 1'b1;
        repeat (10) tick();
        run_op("mul_after_rst", F_MUL, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, LAT + 1, 2'b00);

        check("sb_empty_end", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
